// File: rtl/target_spawner_pkg.sv
// Shared game constants and FSM state encoding used by the
// target spawner, display and hit-decoder blocks.
package target_spawner_pkg;

    localparam int NUM_TARGETS = 10;
    localparam int IDX_W       = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        GAMEOVER = 2'd2
    } game_state_t;

    function automatic logic [IDX_W:0] count_ones(
        input logic [NUM_TARGETS-1:0] v
    );
        logic [IDX_W:0] n;
        n = '0;
        for (int i = 0; i < NUM_TARGETS; i++) begin
            n = n + {{IDX_W{1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/target_spawner_free_slot_finder.sv
// Rotate-and-priority search: first clear bit of mask at or
// above start_idx, wrapping modulo NUM_TARGETS.
module free_slot_finder
    import target_spawner_pkg::*;
(
    input  logic [NUM_TARGETS-1:0] mask,
    input  logic [IDX_W-1:0]       start_idx,
    output logic                   found,
    output logic [IDX_W-1:0]       idx
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] pos;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        sum   = '0;
        pos   = '0;
        for (int k = 0; k < NUM_TARGETS; k++) begin
            sum = {1'b0, start_idx} + (IDX_W+1)'(k);
            pos = (sum >= (IDX_W+1)'(NUM_TARGETS))
                ? IDX_W'(sum - (IDX_W+1)'(NUM_TARGETS))
                : sum[IDX_W-1:0];
            if (!found && !mask[pos]) begin
                found = 1'b1;
                idx   = pos;
            end
        end
    end

endmodule

// File: rtl/target_spawner.sv
// Live-target bookkeeping: paced spawns from the random index,
// hit/expiry retirement, score, misses and game-over control.
module target_spawner
    import target_spawner_pkg::*;
#(
    parameter int SPAWN_PERIOD = 8,
    parameter int LIFETIME     = 24,
    parameter int MAX_MISSES   = 5,
    parameter int RNG_OFFSET   = 13
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic                   start,
    input  logic                   tick,
    input  logic [31:0]            ran_num_ten,
    input  logic                   hit_valid,
    input  logic [IDX_W-1:0]       hit_idx,
    output logic [NUM_TARGETS-1:0] target_mask,
    output logic [31:0]            score,
    output logic [7:0]             misses,
    output logic                   game_over,
    output logic [31:0]            rng_modulus
);

    localparam int SPAWN_W = (SPAWN_PERIOD > 1) ? $clog2(SPAWN_PERIOD) : 1;
    localparam int LIFE_W  = $clog2(LIFETIME + 1);

    game_state_t            state, state_n;
    logic [SPAWN_W-1:0]     spawn_cnt;
    logic                   clear, run, spawn_due, spawn_now;
    logic                   free_found, hit_live, hit_bad;
    logic [IDX_W-1:0]       free_idx;
    logic [NUM_TARGETS-1:0] expire_vec, hit_vec, spawn_vec, mask_n;
    logic [IDX_W:0]         expire_cnt;
    logic [8:0]             miss_sum;
    logic [7:0]             misses_n;
    logic [31:0]            score_n;

    // Probe runs on the registered mask, so a slot freed this
    // cycle only becomes spawnable on the next one.
    free_slot_finder u_finder (
        .mask      (target_mask),
        .start_idx (ran_num_ten[IDX_W-1:0]),
        .found     (free_found),
        .idx       (free_idx)
    );

    assign run       = (state == RUN);
    assign spawn_due = run && tick
                    && (spawn_cnt == SPAWN_W'(SPAWN_PERIOD - 1));

    always_comb begin
        state_n = state;
        clear   = 1'b0;
        unique case (state)
            IDLE, GAMEOVER: begin
                if (start) begin
                    state_n = RUN;
                    clear   = 1'b1;
                end
            end
            RUN: begin
                if (misses >= 8'(MAX_MISSES)) state_n = GAMEOVER;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        spawn_now = spawn_due && free_found
                 && (ran_num_ten < 32'(NUM_TARGETS));
        spawn_vec = spawn_now ? (NUM_TARGETS'(1) << free_idx) : '0;
        hit_live  = run && hit_valid
                 && (hit_idx < IDX_W'(NUM_TARGETS))
                 && target_mask[hit_idx];
        hit_bad   = run && hit_valid && !hit_live;
        hit_vec   = hit_live ? (NUM_TARGETS'(1) << hit_idx) : '0;
        mask_n    = (target_mask & ~expire_vec & ~hit_vec) | spawn_vec;
        // A hit on an expiring slot scores instead of missing.
        expire_cnt = count_ones(expire_vec & ~hit_vec);
        miss_sum   = {1'b0, misses} + 9'(expire_cnt) + 9'(hit_bad);
        misses_n   = miss_sum[8] ? 8'hFF : miss_sum[7:0];
        score_n    = score + 32'(hit_live);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state       <= IDLE;
            target_mask <= '0;
            score       <= '0;
            misses      <= '0;
            game_over   <= 1'b0;
            rng_modulus <= 32'(RNG_OFFSET);
            spawn_cnt   <= '0;
        end else begin
            state     <= state_n;
            game_over <= (state_n == GAMEOVER);
            if (clear) begin
                target_mask <= '0;
                score       <= '0;
                misses      <= '0;
                rng_modulus <= 32'(RNG_OFFSET);
                spawn_cnt   <= '0;
            end else if (run) begin
                target_mask <= mask_n;
                score       <= score_n;
                misses      <= misses_n;
                rng_modulus <= score_n + 32'(RNG_OFFSET);
                if (tick) spawn_cnt <= spawn_due ? '0 : spawn_cnt + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NUM_TARGETS; i++) begin : g_slot
        logic [LIFE_W-1:0] life;

        assign expire_vec[i] = run && tick && target_mask[i]
                            && (life == LIFE_W'(1));

        always_ff @(posedge clock) begin
            if (!resetn || clear) begin
                life <= '0;
            end else if (spawn_vec[i]) begin
                life <= LIFE_W'(LIFETIME);
            end else if (run && tick && target_mask[i]) begin
                life <= life - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_target_spawner.sv
// Directed bench for target_spawner: default instance plus a
// fast-spawn instance so all ten slots can be live at once.
module tb_target_spawner;
    import target_spawner_pkg::*;

    logic                   clock = 1'b0;
    logic                   resetn, start, tick, hit_valid;
    logic [31:0]            ran;
    logic [IDX_W-1:0]       hit_idx;
    logic [NUM_TARGETS-1:0] mask;
    logic [31:0]            score, rng;
    logic [7:0]             misses;
    logic                   game_over;

    logic                   f_resetn, f_start, f_tick, f_hit_valid;
    logic [31:0]            f_ran;
    logic [IDX_W-1:0]       f_hit_idx;
    logic [NUM_TARGETS-1:0] f_mask;
    logic [31:0]            f_score, f_rng;
    logic [7:0]             f_misses;
    logic                   f_game_over;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    target_spawner u_dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .tick        (tick),
        .ran_num_ten (ran),
        .hit_valid   (hit_valid),
        .hit_idx     (hit_idx),
        .target_mask (mask),
        .score       (score),
        .misses      (misses),
        .game_over   (game_over),
        .rng_modulus (rng)
    );

    target_spawner #(.SPAWN_PERIOD(2)) u_fast (
        .clock       (clock),
        .resetn      (f_resetn),
        .start       (f_start),
        .tick        (f_tick),
        .ran_num_ten (f_ran),
        .hit_valid   (f_hit_valid),
        .hit_idx     (f_hit_idx),
        .target_mask (f_mask),
        .score       (f_score),
        .misses      (f_misses),
        .game_over   (f_game_over),
        .rng_modulus (f_rng)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        cyc(n);
        tick = 1'b0;
    endtask

    task automatic f_ticks(input int n);
        f_tick = 1'b1;
        cyc(n);
        f_tick = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; tick = 1'b0; hit_valid = 1'b0;
        ran = '0; hit_idx = '0;
        f_resetn = 1'b0; f_start = 1'b0; f_tick = 1'b0;
        f_hit_valid = 1'b0; f_ran = '0; f_hit_idx = '0;
        cyc(2);
        resetn = 1'b1; f_resetn = 1'b1;

        chk("reset_mask", 32'(mask), 32'h0);
        chk("reset_score", score, 32'd0);
        chk("reset_misses", 32'(misses), 32'd0);
        chk("reset_game_over", 32'(game_over), 32'd0);
        chk("reset_rng", rng, 32'd13);

        start = 1'b1; cyc(1); start = 1'b0;
        ran = 32'd3;
        ticks(7);
        chk("no_spawn_before_period", 32'(mask), 32'h000);
        ticks(1);
        chk("first_spawn_slot3", 32'(mask), 32'h008);
        chk("rng_after_spawn", rng, 32'd13);

        ticks(8);
        chk("probe_to_slot4", 32'(mask), 32'h018);
        ran = 32'd12;
        ticks(8);
        chk("skip_invalid_index", 32'(mask), 32'h018);

        ticks(7);
        tick = 1'b1; hit_valid = 1'b1; hit_idx = 4'd3;
        cyc(1);
        tick = 1'b0; hit_valid = 1'b0;
        chk("hit_vs_expiry_score", score, 32'd1);
        chk("hit_vs_expiry_misses", 32'(misses), 32'd0);
        chk("hit_vs_expiry_mask", 32'(mask), 32'h010);
        chk("rng_tracks_score", rng, 32'd14);

        resetn = 1'b0; cyc(1); resetn = 1'b1;
        chk("midgame_reset_score", score, 32'd0);
        start = 1'b1; cyc(1); start = 1'b0;
        ran = 32'd0;
        ticks(40);
        chk("expiry_mask_t40", 32'(mask), 32'h00D);
        chk("expiry_misses_t40", 32'(misses), 32'd2);
        ran = 32'd12;
        ticks(24);
        chk("five_misses", 32'(misses), 32'd5);
        chk("game_over_lag", 32'(game_over), 32'd0);
        chk("all_expired_mask", 32'(mask), 32'h000);
        cyc(1);
        chk("game_over_set", 32'(game_over), 32'd1);
        hit_valid = 1'b1; hit_idx = 4'd0; cyc(1); hit_valid = 1'b0;
        chk("gameover_hit_misses", 32'(misses), 32'd5);
        chk("gameover_hit_score", score, 32'd0);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("restart_game_over", 32'(game_over), 32'd0);
        chk("restart_misses", 32'(misses), 32'd0);

        f_start = 1'b1; cyc(1); f_start = 1'b0;
        f_ran = 32'd0;
        f_ticks(20);
        chk("fill_all_slots", 32'(f_mask), 32'h3FF);
        f_ran = 32'd5;
        f_ticks(2);
        chk("full_spawn_skipped", 32'(f_mask), 32'h3FF);
        chk("full_no_miss", 32'(f_misses), 32'd0);
        f_hit_valid = 1'b1; f_hit_idx = 4'd11; cyc(1); f_hit_valid = 1'b0;
        chk("bad_index_miss", 32'(f_misses), 32'd1);
        chk("bad_index_mask", 32'(f_mask), 32'h3FF);
        f_hit_valid = 1'b1; f_hit_idx = 4'd5; cyc(1); f_hit_valid = 1'b0;
        chk("live_hit_score", f_score, 32'd1);
        chk("live_hit_mask", 32'(f_mask), 32'h3DF);
        chk("live_hit_rng", f_rng, 32'd14);

        f_resetn = 1'b0; cyc(1); f_resetn = 1'b1;
        f_start = 1'b1; cyc(1); f_start = 1'b0;
        f_ran = 32'd0; f_ticks(2);
        f_ran = 32'd2; f_ticks(2);
        f_ran = 32'd5; f_ticks(2);
        f_ran = 32'd7; f_ticks(2);
        f_ran = 32'd9; f_ticks(2);
        chk("pattern_2a5", 32'(f_mask), 32'h2A5);
        f_resetn = 1'b0; cyc(1); f_resetn = 1'b1;
        chk("rst_mask", 32'(f_mask), 32'h0);
        chk("rst_score", f_score, 32'd0);
        chk("rst_misses", 32'(f_misses), 32'd0);
        chk("rst_game_over", 32'(f_game_over), 32'd0);
        chk("rst_rng", f_rng, 32'd13);
        f_ran = 32'd1;
        f_ticks(4);
        chk("idle_needs_start", 32'(f_mask), 32'h0);
        f_start = 1'b1; cyc(1); f_start = 1'b0;
        f_ticks(2);
        chk("resume_after_start", 32'(f_mask), 32'h002);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/target_spawner.md
# target_spawner

Consumes the 0–9 random index from the random number generator and maintains the set of live on-screen targets for the game. Spawns targets at a fixed pace, retires them on player hit or lifetime expiry, keeps score and miss count, and ends the game after too many misses. Also returns a never-zero modulus to the generator, closing the score→random loop.

## Interface
- `NUM_TARGETS`, 10, number of target slots; indices 0..NUM_TARGETS-1
- `SPAWN_PERIOD`, 8, `tick` pulses between spawn attempts
- `LIFETIME`, 24, `tick` pulses a target stays live before expiring
- `MAX_MISSES`, 5, miss count that ends the game
- `RNG_OFFSET`, 13, constant added to score for `rng_modulus`
- `clock`  in  1  sole clock, all logic on posedge
- `resetn`  in  1  synchronous, active-low reset
- `start`  in  1  one-cycle pulse; begins a game from IDLE or GAMEOVER
- `tick`  in  1  one-cycle game-pace enable; all countdowns advance only on it
- `ran_num_ten`  in  32  random index from generator; valid values 0..9
- `hit_valid`  in  1  one-cycle pulse: player struck `hit_idx`
- `hit_idx`  in  4  struck slot index
- `target_mask`  out  10  bit i = slot i live
- `score`  out  32  count of successful hits this game
- `misses`  out  8  count of expiries plus wrong hits this game
- `game_over`  out  1  high while in GAMEOVER
- `rng_modulus`  out  32  `score + RNG_OFFSET`; feeds the generator's score input, never zero

## Operation
- FSM states: IDLE, RUN, GAMEOVER.
- IDLE → RUN on `start`. Clears the mask, score, misses, per-slot lifetimes, and spawn counter.
- RUN → GAMEOVER when the registered `misses` ≥ MAX_MISSES.
- GAMEOVER → RUN on `start`, with the same clears as above. Otherwise GAMEOVER holds all outputs frozen.
- Spawn counter: counts `tick`s in RUN. On reaching SPAWN_PERIOD-1 with `tick`, it wraps to 0 and makes a spawn attempt that cycle.
- Spawn attempt: sample `ran_num_ten`.
  - If ≥ NUM_TARGETS, the spawn is skipped and nothing changes.
  - Otherwise, probe from that index upward, wrapping mod NUM_TARGETS, and take the first slot not live in the current registered mask. Set its bit and load its lifetime to LIFETIME.
  - If all slots are live, the spawn is skipped.
- Lifetime: on each `tick` in RUN, every live slot decrements. A slot whose lifetime is 1 at that `tick` is cleared and adds 1 to misses.
- Hit: `hit_valid` in RUN.
  - If `hit_idx` < NUM_TARGETS and that slot is live, clear it and add 1 to score.
  - Otherwise (dead slot or index ≥ NUM_TARGETS), add 1 to misses.
  - Hits outside RUN are ignored.
- Simultaneous events on the same slot in one cycle:
  - Hit beats expiry: score +1, no miss.
  - A spawn cannot land on a slot live in the registered mask, so a slot cleared this cycle becomes spawnable only on the next cycle.
- Misses from one expiry sweep and one wrong hit in the same cycle are summed.
- Counter saturation:
  - Misses saturate at 255.
  - Score wraps modulo 2^32.
  - `rng_modulus` is computed in 32 bits. Because the offset keeps it ≥ 13 in practice, the generator never sees a zero divisor.

## Timing
- All outputs are registered. Effects of `start`, `tick`, and `hit_valid` are visible on the next posedge.
- Hit → `target_mask` or `score` update: 1 cycle.
- `rng_modulus` is registered from the same edge as `score`, with no extra lag.
- `game_over` rises 1 cycle after `misses` reaches MAX_MISSES.
- Reset values:
  - state IDLE, `target_mask` 0, `score` 0, `misses` 0, `game_over` 0
  - `rng_modulus` RNG_OFFSET
  - internal counters 0
- Reset asserted mid-game returns the block to IDLE on that edge, discarding live targets.
- `ran_num_ten` is sampled only in the spawn cycle. The generator updates every cycle, so no handshake is needed.

## Structure
- Shared game package holds:
  - `NUM_TARGETS`
  - the FSM state enum (IDLE/RUN/GAMEOVER)
  - the index width constant (4)
- The package is reused by the display and hit-decoder blocks.
- One natural sub-module: `free_slot_finder`. It is a combinational rotate-and-priority search that takes the mask and start index and returns `found` plus the slot index.
- Per-slot lifetime counters are a generate loop in the top.

## Test plan
- Reset, `start`, then 8 ticks with `ran_num_ten`=3. Expect `target_mask`=0x008 after the 8th tick, and `rng_modulus`=13.
- Slot 3 live and `ran_num_ten`=3 at the next spawn. Expect the probe to pick slot 4, giving mask 0x018. With `ran_num_ten`=12, no spawn occurs.
- `hit_valid` on `hit_idx`=3 in the same cycle slot 3's lifetime reaches expiry. Expect `score`=1, `misses`=0, and mask bit 3 clear.
- Let 5 targets expire with no hits. Expect `misses`=5 and `game_over`=1 one cycle later. A subsequent hit changes nothing.
- Fill all 10 slots, then attempt a spawn. Expect the mask to stay at 0x3FF. A hit on `hit_idx`=11 gives `misses`+1.
- Drive `resetn`=0 for one cycle mid-RUN with mask 0x2A5. Expect all outputs at their reset values next cycle, and `start` needed to resume.
